// File: rtl/ember_pkg.sv
// Shared definitions for the thread-array / shared-ALU glue logic:
// ALU opcode width, flag bit positions and the ALU arbiter state encoding.
package ember_pkg;

  localparam int ALU_OP_W = 8;
  localparam int N_FLAGS  = 6;

  // rsp_flags layout is {zero, carry, overflow, lt, eq, gt}
  localparam int FLG_GT       = 0;
  localparam int FLG_EQ       = 1;
  localparam int FLG_LT       = 2;
  localparam int FLG_OVERFLOW = 3;
  localparam int FLG_CARRY    = 4;
  localparam int FLG_ZERO     = 5;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_BUSY    = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request strictly after rr_ptr,
// wrapping around. Kept generic so other shared-port arbiters can reuse it.
module rr_picker #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [IW-1:0] winner,
  output logic          any
);

  localparam int DW = $clog2(2 * N);

  logic [2*N-1:0] req_dbl;
  logic [DW-1:0]  idx;
  logic [DW-1:0]  idx_wrap;

  // Doubling the vector turns the wrap-around scan into a straight priority scan.
  always_comb begin
    req_dbl  = {req, req};
    winner   = '0;
    any      = 1'b0;
    idx      = '0;
    idx_wrap = '0;
    for (int i = 1; i <= N; i++) begin
      idx = DW'(rr_ptr) + DW'(i);
      if (!any && req_dbl[idx]) begin
        any      = 1'b1;
        idx_wrap = (idx >= DW'(N)) ? idx - DW'(N) : idx;
        winner   = idx_wrap[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among N_THREADS thread cores, with a
// watchdog that aborts an operation the ALU never completes.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ARB_IDLE    | waiting for any req_valid; picks winner and latches operands
// ARB_ISSUE   | alu_start high for this single cycle; watchdog cleared
// ARB_BUSY    | waiting for alu_done or watchdog terminal count
// ARB_RELEASE | dead cycle so the requester can drop req_valid
module alu_arbiter
  import ember_pkg::*;
#(
  parameter int N_THREADS = 4,
  parameter int DATA_W    = 64,
  parameter int TIMEOUT   = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_THREADS-1:0]            req_valid,
  input  logic [N_THREADS*ALU_OP_W-1:0]   req_op,
  input  logic [N_THREADS*DATA_W-1:0]     req_a,
  input  logic [N_THREADS*DATA_W-1:0]     req_b,
  output logic [N_THREADS-1:0]            req_done,
  output logic [N_THREADS-1:0]            req_err,
  output logic [DATA_W-1:0]               rsp_res,
  output logic [N_FLAGS-1:0]              rsp_flags,
  output logic                            alu_start,
  output logic [ALU_OP_W-1:0]             alu_op,
  output logic [DATA_W-1:0]               alu_a,
  output logic [DATA_W-1:0]               alu_b,
  input  logic [DATA_W-1:0]               alu_res,
  input  logic                            alu_zero,
  input  logic                            alu_carry,
  input  logic                            alu_overflow,
  input  logic                            alu_lt,
  input  logic                            alu_eq,
  input  logic                            alu_gt,
  input  logic                            alu_done,
  output logic                            busy,
  output logic [$clog2(N_THREADS)-1:0]    grant_id
);

  localparam int IW    = $clog2(N_THREADS);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t         state;
  logic [IW-1:0]      rr_ptr;
  logic [CNT_W-1:0]   wd_cnt;
  logic [IW-1:0]      pick_winner;
  logic               pick_any;
  logic [N_FLAGS-1:0] alu_flags;

  logic [ALU_OP_W-1:0] op_arr [N_THREADS];
  logic [DATA_W-1:0]   a_arr  [N_THREADS];
  logic [DATA_W-1:0]   b_arr  [N_THREADS];

  for (genvar g = 0; g < N_THREADS; g++) begin : g_split
    assign op_arr[g] = req_op[g*ALU_OP_W +: ALU_OP_W];
    assign a_arr[g]  = req_a[g*DATA_W +: DATA_W];
    assign b_arr[g]  = req_b[g*DATA_W +: DATA_W];
  end

  always_comb begin
    alu_flags               = '0;
    alu_flags[FLG_ZERO]     = alu_zero;
    alu_flags[FLG_CARRY]    = alu_carry;
    alu_flags[FLG_OVERFLOW] = alu_overflow;
    alu_flags[FLG_LT]       = alu_lt;
    alu_flags[FLG_EQ]       = alu_eq;
    alu_flags[FLG_GT]       = alu_gt;
  end

  rr_picker #(.N(N_THREADS)) u_picker (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .winner (pick_winner),
    .any    (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      rr_ptr    <= IW'(N_THREADS - 1);
      wd_cnt    <= '0;
      grant_id  <= '0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_start <= 1'b0;
      busy      <= 1'b0;
      req_done  <= '0;
      req_err   <= '0;
      rsp_res   <= '0;
      rsp_flags <= '0;
    end else begin
      alu_start <= 1'b0;
      req_done  <= '0;
      req_err   <= '0;
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_id  <= pick_winner;
            rr_ptr    <= pick_winner;
            alu_op    <= op_arr[pick_winner];
            alu_a     <= a_arr[pick_winner];
            alu_b     <= b_arr[pick_winner];
            alu_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          wd_cnt <= '0;
          state  <= ARB_BUSY;
        end
        ARB_BUSY: begin
          // Done wins over a watchdog expiry in the same cycle; a requester
          // that dropped req_valid gets no pulse either way.
          if (alu_done) begin
            rsp_res   <= alu_res;
            rsp_flags <= alu_flags;
            if (req_valid[grant_id]) req_done[grant_id] <= 1'b1;
            state <= ARB_RELEASE;
          end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
            if (req_valid[grant_id]) req_err[grant_id] <= 1'b1;
            state <= ARB_RELEASE;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        ARB_RELEASE: begin
          busy  <= 1'b0;
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: randomized transactions checked against
// a cycle-timeline reference model of round-robin grant, done/err and timeout.
module tb_alu_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int TO = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_op;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_done, req_err;
  logic [W-1:0]   rsp_res;
  logic [5:0]     rsp_flags;
  logic           alu_start;
  logic [7:0]     alu_op;
  logic [W-1:0]   alu_a, alu_b, alu_res;
  logic           alu_zero, alu_carry, alu_overflow, alu_lt, alu_eq, alu_gt;
  logic           alu_done;
  logic           busy;
  logic [1:0]     grant_id;

  int n_checks = 0;
  int n_errors = 0;

  int         last_grant;
  logic [W-1:0] exp_res;
  logic [5:0]   exp_flags;
  logic [7:0]   op_v [N];
  logic [W-1:0] a_v  [N];
  logic [W-1:0] b_v  [N];
  logic [W-1:0] res_v;
  logic [5:0]   flg_v;
  int           order [5];

  always #5 clk = ~clk;

  alu_arbiter #(.N_THREADS(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_done(req_done), .req_err(req_err), .rsp_res(rsp_res), .rsp_flags(rsp_flags),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .alu_lt(alu_lt), .alu_eq(alu_eq), .alu_gt(alu_gt),
    .alu_done(alu_done), .busy(busy), .grant_id(grant_id)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic done, input logic [W-1:0] r, input logic [5:0] f);
    alu_done = done;
    alu_res  = r;
    {alu_zero, alu_carry, alu_overflow, alu_lt, alu_eq, alu_gt} = f;
  endtask

  task automatic rand_all();
    for (int i = 0; i < N; i++) begin
      op_v[i] = 8'($urandom);
      a_v[i]  = {$urandom, $urandom};
      b_v[i]  = {$urandom, $urandom};
    end
    res_v = {$urandom, $urandom};
    flg_v = 6'($urandom);
  endtask

  task automatic pack_operands();
    for (int i = 0; i < N; i++) begin
      req_op[i*8 +: 8] = op_v[i];
      req_a[i*W +: W]  = a_v[i];
      req_b[i*W +: W]  = b_v[i];
    end
  endtask

  // Next requester after the last grant, wrapping modulo N.
  function automatic int model_pick(input logic [N-1:0] m);
    int j;
    for (int i = 1; i <= N; i++) begin
      j = (last_grant + i) % N;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    drive_alu(1'b0, '0, '0);
    step();
    step();
    rst        = 1'b0;
    last_grant = N - 1;
    exp_res    = '0;
    exp_flags  = '0;
  endtask

  // Starts in an IDLE cycle, ends in the following IDLE cycle.
  // k = ALU latency after alu_start (1..); k = 0 means the ALU never answers.
  task automatic run_txn(input logic [N-1:0] mask, input int k, input bit drop, input string tag);
    int w, end_c;
    bit is_done;
    logic [N-1:0] onehot, exp_done, exp_err;
    w       = model_pick(mask);
    is_done = (k >= 1 && k <= TO);
    end_c   = is_done ? 1 + k : 1 + TO;
    pack_operands();
    req_valid = mask;
    drive_alu(1'b0, '0, '0);
    step();
    n_checks++;
    if ({alu_start, busy, 2'(grant_id)} !== {1'b1, 1'b1, 2'(w)}) begin
      n_errors++;
      $display("FAIL %s issue start/busy/grant got %b/%b/%0d want 1/1/%0d", tag, alu_start, busy, grant_id, w);
    end
    n_checks++;
    if ({alu_op, alu_a, alu_b} !== {op_v[w], a_v[w], b_v[w]}) begin
      n_errors++;
      $display("FAIL %s operands got op=%h a=%h b=%h want op=%h a=%h b=%h", tag, alu_op, alu_a, alu_b, op_v[w], a_v[w], b_v[w]);
    end
    last_grant = w;
    for (int c = 1; c <= end_c; c++) begin
      if (c >= 2) begin
        req_valid    = 4'($urandom);
        req_valid[w] = !drop;
      end
      if (c == 1 && k > 1) drive_alu(1'b1, ~res_v, ~flg_v);
      else drive_alu(is_done && (c == 1 + k), res_v, flg_v);
      step();
      if (c + 1 <= end_c) begin
        n_checks++;
        if ({req_done, req_err, alu_start, busy, 2'(grant_id)} !== {4'b0, 4'b0, 1'b0, 1'b1, 2'(w)}) begin
          n_errors++;
          $display("FAIL %s busy cycle %0d done=%b err=%b start=%b busy=%b grant=%0d want 0000/0000/0/1/%0d",
                   tag, c + 1, req_done, req_err, alu_start, busy, grant_id, w);
        end
      end
    end
    drive_alu(1'b0, '0, '0);
    onehot   = 4'(1 << w);
    exp_done = (is_done && !drop) ? onehot : '0;
    exp_err  = (!is_done && !drop) ? onehot : '0;
    if (is_done) begin
      exp_res   = res_v;
      exp_flags = flg_v;
    end
    n_checks++;
    if (req_done !== exp_done) begin
      n_errors++;
      $display("FAIL %s req_done got %b want %b", tag, req_done, exp_done);
    end
    n_checks++;
    if (req_err !== exp_err) begin
      n_errors++;
      $display("FAIL %s req_err got %b want %b", tag, req_err, exp_err);
    end
    n_checks++;
    if ({rsp_res, rsp_flags} !== {exp_res, exp_flags}) begin
      n_errors++;
      $display("FAIL %s rsp got res=%h flags=%b want res=%h flags=%b", tag, rsp_res, rsp_flags, exp_res, exp_flags);
    end
    n_checks++;
    if ({busy, alu_op} !== {1'b1, op_v[w]}) begin
      n_errors++;
      $display("FAIL %s release busy/op got %b/%h want 1/%h", tag, busy, alu_op, op_v[w]);
    end
    req_valid = '0;
    drive_alu(1'($urandom), {$urandom, $urandom}, 6'($urandom));
    step();
    drive_alu(1'b0, '0, '0);
    n_checks++;
    if ({busy, alu_start, req_done, req_err, rsp_res} !== {1'b0, 1'b0, 4'b0, 4'b0, exp_res}) begin
      n_errors++;
      $display("FAIL %s back in idle busy=%b start=%b done=%b err=%b res=%h want 0/0/0000/0000/%h",
               tag, busy, alu_start, req_done, req_err, rsp_res, exp_res);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'($urandom);
    rand_all();
    pack_operands();
    drive_alu(1'b1, res_v, flg_v);
    step();
    step();
    n_checks++;
    if ({req_done, req_err, rsp_res, rsp_flags, alu_start, alu_op, alu_a, alu_b, busy, grant_id} !== '0) begin
      n_errors++;
      $display("FAIL reset outputs done=%b err=%b res=%h flags=%b start=%b op=%h busy=%b grant=%0d want all zero",
               req_done, req_err, rsp_res, rsp_flags, alu_start, alu_op, busy, grant_id);
    end
    do_reset();
  endtask

  task automatic test_idle_no_request();
    for (int i = 0; i < 6; i++) begin
      req_valid = '0;
      drive_alu(1'($urandom), {$urandom, $urandom}, 6'($urandom));
      step();
      n_checks++;
      if ({busy, alu_start, req_done, req_err, rsp_res} !== {1'b0, 1'b0, 4'b0, 4'b0, exp_res}) begin
        n_errors++;
        $display("FAIL idle busy=%b start=%b done=%b err=%b res=%h want 0/0/0000/0000/%h",
                 busy, alu_start, req_done, req_err, rsp_res, exp_res);
      end
    end
    drive_alu(1'b0, '0, '0);
  endtask

  task automatic test_single();
    do_reset();
    rand_all();
    op_v[0] = 8'h01;
    a_v[0]  = 64'd5;
    b_v[0]  = 64'd3;
    res_v   = 64'd8;
    flg_v   = 6'b000001;
    run_txn(4'b0001, 2, 1'b0, "single");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rand_all();
      run_txn(4'b1111, int'($urandom_range(1, 6)), 1'b0, "rr");
      order[i] = int'(grant_id);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (order[i] !== i % N) begin
        n_errors++;
        $display("FAIL rr_order slot %0d got %0d want %0d", i, order[i], i % N);
      end
    end
  endtask

  task automatic test_drop();
    do_reset();
    rand_all();
    res_v = 64'hAA;
    run_txn(4'b0100, 3, 1'b1, "drop");
    rand_all();
    run_txn(4'b1011, 2, 1'b0, "after_drop");
  endtask

  task automatic test_timeout();
    rand_all();
    run_txn(4'b0010, 0, 1'b0, "timeout");
    rand_all();
    run_txn(4'b1001, TO, 1'b0, "done_at_tc");
    rand_all();
    run_txn(4'b0110, 0, 1'b1, "timeout_drop");
    rand_all();
    run_txn(4'b0001, TO - 1, 1'b0, "done_before_tc");
  endtask

  task automatic test_reset_mid_busy();
    rand_all();
    pack_operands();
    req_valid = 4'b0110;
    step();
    step();
    step();
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if ({req_done, req_err, rsp_res, rsp_flags, alu_start, alu_op, alu_a, alu_b, busy, grant_id} !== '0) begin
      n_errors++;
      $display("FAIL mid_busy_reset outputs done=%b err=%b res=%h start=%b busy=%b grant=%0d want all zero",
               req_done, req_err, rsp_res, alu_start, busy, grant_id);
    end
    rst       = 1'b0;
    req_valid = '0;
    drive_alu(1'b1, {$urandom, $urandom}, 6'($urandom));
    step();
    drive_alu(1'b0, '0, '0);
    n_checks++;
    if ({req_done, req_err, busy, alu_start, rsp_res, rsp_flags} !== '0) begin
      n_errors++;
      $display("FAIL stale_done done=%b err=%b busy=%b start=%b res=%h flags=%b want all zero",
               req_done, req_err, busy, alu_start, rsp_res, rsp_flags);
    end
    last_grant = N - 1;
    exp_res    = '0;
    exp_flags  = '0;
    rand_all();
    run_txn(4'b1111, 2, 1'b0, "post_reset");
  endtask

  task automatic test_random();
    logic [N-1:0] m;
    int k;
    for (int i = 0; i < 40; i++) begin
      rand_all();
      m = 4'($urandom_range(1, 15));
      k = (i % 10 == 9) ? 0 : int'($urandom_range(1, 10));
      run_txn(m, k, ($urandom_range(0, 5) == 0), "random");
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    drive_alu(1'b0, '0, '0);
    last_grant = N - 1;
    exp_res    = '0;
    exp_flags  = '0;
    test_reset();
    test_idle_no_request();
    test_single();
    test_round_robin();
    test_drop();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares a single ALU between N_THREADS thread cores using round-robin arbitration.
- Latches the winning thread's operation and operands, then issues them to the ALU as a one-cycle start pulse.
- Waits for the ALU's done signal, then returns the result and flags to the winning thread only.
- Sits between the thread array and the shared ALU, and has a watchdog that recovers from a hung ALU.

Parameters:
- N_THREADS, 4, number of requesting threads (2..16).
- DATA_W, 64, operand/result width.
- TIMEOUT, 64, max cycles in BUSY before the operation is aborted with an error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  N_THREADS  per-thread request; level, held until that thread's req_done
- req_op  in  N_THREADS*8  per-thread ALU opcode; slice i = [8i+7:8i]
- req_a  in  N_THREADS*DATA_W  per-thread operand A
- req_b  in  N_THREADS*DATA_W  per-thread operand B
- req_done  out  N_THREADS  one-cycle completion pulse, one-hot
- req_err  out  N_THREADS  one-cycle abort pulse (timeout), one-hot
- rsp_res  out  DATA_W  result, broadcast to all threads, valid with req_done
- rsp_flags  out  6  {zero,carry,overflow,lt,eq,gt}, valid with req_done
- alu_start  out  1  one-cycle issue pulse to the ALU
- alu_op  out  8  opcode to the ALU, held stable through BUSY
- alu_a  out  DATA_W  operand A to the ALU, held stable through BUSY
- alu_b  out  DATA_W  operand B to the ALU, held stable through BUSY
- alu_res  in  DATA_W  ALU result
- alu_zero, alu_carry, alu_overflow, alu_lt, alu_eq, alu_gt  in  1 each  ALU flags
- alu_done  in  1  ALU completion, sampled only in BUSY
- busy  out  1  high in ISSUE/BUSY/RELEASE
- grant_id  out  clog2(N_THREADS)  current/last granted thread

Behaviour:
- Reset values: all outputs 0; state=IDLE; rr_ptr=N_THREADS-1 (so thread 0 wins first); timeout counter 0.
- IDLE:
  - If any req_valid is set, the winner is the first set bit scanning from rr_ptr+1 upward, with wrap-around.
  - Register grant_id=winner; latch req_op/req_a/req_b slices into alu_op/alu_a/alu_b; rr_ptr<=winner; go to ISSUE.
- ISSUE: alu_start=1 for exactly this cycle; counter<=0; go to BUSY.
- BUSY:
  - alu_done=1: latch alu_res into rsp_res and the flags into rsp_flags.
    - If req_valid[grant_id] is still 1, pulse req_done[grant_id] next cycle.
    - If it is 0 (requester soft-reset), discard the result with no pulse.
    - Go to RELEASE.
  - Else, counter==TIMEOUT-1: pulse req_err[grant_id] (gated by req_valid the same way); rsp_res and rsp_flags unchanged; go to RELEASE.
  - Else: counter++.
- RELEASE: one dead cycle so the requester can drop req_valid; no grant is made; go to IDLE.
- Latency:
  - Request seen in IDLE at cycle 0 -> alu_start at cycle 1.
  - ALU done at cycle 1+k -> req_done at cycle 2+k.
  - Next grant is possible at cycle 3+k.
- Fairness: a requester waits at most N_THREADS-1 other operations.
- alu_done outside BUSY is ignored. A simultaneous alu_done and timeout resolves as done.
- req_done and req_err are mutually exclusive, one-hot, and never asserted for a non-granted thread.
- Requests that rise or fall outside IDLE do not affect the current grant.
- rst at any point returns to IDLE with no pulses.
  - The in-flight ALU operation is abandoned.
  - A stale alu_done arriving after reset is ignored because state≠BUSY.
- Operand slices are indexed as i*DATA_W +: DATA_W. The winner search is a for-loop priority scan over a doubled request vector.

Decomposition:
- Shared package (ember_pkg):
  - ALU flag bit-index constants: FLG_ZERO..FLG_GT.
  - ALU_OP_W=8.
  - Arbiter state encoding: ARB_IDLE/ISSUE/BUSY/RELEASE.
- Sub-module rr_picker: purely combinational round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: winner index, any.
  - Reusable later for the L1-D port arbiter.

Test Plan:
- Single request: req_valid=0001, op=0x01, a=5, b=3; ALU model done after 2 cycles with res=8 -> alu_start at cycle 1 with op=0x01, a=5, b=3; req_done=0001 at cycle 4; rsp_res=8.
- All four requesting continuously, reset rr_ptr -> grant order 0,1,2,3,0; each req_done one-hot; no thread granted twice before the others are served.
- Thread 2 drops req_valid while in BUSY; ALU returns res=0xAA -> no req_done/req_err pulse; next grant proceeds normally.
- ALU never asserts done, TIMEOUT=64 -> req_err[grant] pulses 65 cycles after alu_start; arbiter returns to IDLE; rsp_res unchanged.
- alu_done in the same cycle as the timeout terminal count -> req_done asserted, req_err not asserted.
- rst asserted mid-BUSY, followed by alu_done -> all outputs 0, state IDLE, no done pulse; first post-reset grant goes to thread 0.
